// File: rtl/idp_dec_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : idp_dec_arb_if
//  Description : Bundle of the per-lane codeword request channels and the
//                single decoded-word return channel of idp_dec_arb.
//  Revision    : 1.0  initial release
// ============================================================================
interface idp_dec_arb_if #(
   parameter int N_LANES = 4,
   parameter int LANE_W  = 2,
   parameter int DOUT_W  = 17
);
   logic [N_LANES-1:0]    in_valid;
   logic [N_LANES-1:0]    in_ready;
   logic [23*N_LANES-1:0] in_code;
   logic                  out_valid;
   logic                  out_ready;
   logic [DOUT_W-1:0]     out_data;
   logic [LANE_W-1:0]     out_lane;

   // Lane receivers and downstream sink side
   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_data, out_lane
   );

   // Arbiter/decoder side
   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_data, out_lane
   );
endinterface
`default_nettype wire

// File: rtl/idp_dec_arb.sv
`default_nettype none
// ============================================================================
//  Module      : idp_dec_23
//  Description : Combinational CAC decoder. Each codeword bit carries a
//                Fibonacci weight (bit0=1, bit1=2, bit2=3, bit3=5, ...); the
//                decoded value is the sum of the weights of the set bits.
//  Revision    : 1.0  initial release
// ============================================================================
module idp_dec_23 #(
   parameter int DOUT_W = 17
) (
   input  wire logic [22:0]       codein,
   output logic      [DOUT_W-1:0] dataout
);
   logic [DOUT_W-1:0] w_wa;
   logic [DOUT_W-1:0] w_wb;
   logic [DOUT_W-1:0] w_wn;
   logic [DOUT_W-1:0] w_acc;

   // Weighted sum; weights are generated by walking the Fibonacci recurrence
   always_comb begin
      w_acc = '0;
      w_wa  = DOUT_W'(1);
      w_wb  = DOUT_W'(2);
      w_wn  = '0;
      for (int i = 0; i < 23; i++) begin
         if (codein[i]) begin
            w_acc = w_acc + w_wa;
         end
         w_wn = w_wa + w_wb;
         w_wa = w_wb;
         w_wb = w_wn;
      end
      dataout = w_acc;
   end
endmodule

// ============================================================================
//  Module      : idp_dec_arb
//  Description : Round-robin arbiter sharing one idp_dec_23 decoder between
//                N_LANES TSV receive lanes. Two-register pipeline: S1 holds
//                the granted codeword, S2 is the decoded output register.
//  Revision    : 1.0  initial release
// ============================================================================
module idp_dec_arb #(
   parameter int N_LANES = 4,
   parameter int LANE_W  = 2,
   parameter int DOUT_W  = 17
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   idp_dec_arb_if.slave  bus
);
   localparam int c_CODE_W = 23;

   logic                r_s1_valid;
   logic [c_CODE_W-1:0] r_s1_code;
   logic [LANE_W-1:0]   r_s1_lane;
   logic [LANE_W-1:0]   r_rr_ptr;
   logic                r_out_valid;
   logic [DOUT_W-1:0]   r_out_data;
   logic [LANE_W-1:0]   r_out_lane;

   logic                w_s2_free;
   logic                w_s1_free;
   logic                w_found;
   logic [LANE_W-1:0]   w_grant;
   logic [c_CODE_W-1:0] w_sel_code;
   logic [N_LANES-1:0]  w_in_ready;
   logic [LANE_W-1:0]   w_rr_next;
   logic [DOUT_W-1:0]   w_dec;

   // Lane index reached k steps above the round-robin pointer, wrapping
   function automatic int lane_at(input logic [LANE_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= N_LANES) begin
         s = s - N_LANES;
      end
      return s;
   endfunction

   assign w_s2_free = !r_out_valid || bus.out_ready;
   assign w_s1_free = !r_s1_valid || w_s2_free;

   // Grant the first valid lane at or above rr_ptr, only when S1 can load
   always_comb begin
      w_found    = 1'b0;
      w_grant    = '0;
      w_sel_code = '0;
      for (int k = 0; k < N_LANES; k++) begin
         if (!w_found && w_s1_free && bus.in_valid[lane_at(r_rr_ptr, k)]) begin
            w_found    = 1'b1;
            w_grant    = LANE_W'(lane_at(r_rr_ptr, k));
            w_sel_code = bus.in_code[c_CODE_W*lane_at(r_rr_ptr, k) +: c_CODE_W];
         end
      end
   end

   // One-hot accept; forced low while reset is asserted so it drops at once
   always_comb begin
      w_in_ready = '0;
      if (w_found && rst_n) begin
         w_in_ready[w_grant] = 1'b1;
      end
   end

   assign w_rr_next = (w_grant == LANE_W'(N_LANES - 1)) ? '0 : w_grant + LANE_W'(1);

   idp_dec_23 #(
      .DOUT_W (DOUT_W)
   ) u_dec (
      .codein  (r_s1_code),
      .dataout (w_dec)
   );

   // S1 stage and round-robin pointer: load on grant, empty when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_code  <= '0;
         r_s1_lane  <= '0;
         r_rr_ptr   <= '0;
      end else if (w_s1_free) begin
         r_s1_valid <= w_found;
         if (w_found) begin
            r_s1_code <= w_sel_code;
            r_s1_lane <= w_grant;
            r_rr_ptr  <= w_rr_next;
         end
      end
   end

   // S2 output stage: capture decoded S1 word, hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_lane  <= '0;
      end else if (w_s2_free) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data <= w_dec;
            r_out_lane <= r_s1_lane;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_lane  = r_out_lane;
endmodule
`default_nettype wire

// File: tb/tb_idp_dec_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idp_dec_arb
//  Description : Self-checking bench for idp_dec_arb: table of per-cycle
//                stimulus with expected accept/valid, a scoreboard queue of
//                expected decoded words, and hand-written corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_idp_dec_arb;
   localparam int c_N  = 4;
   localparam int c_LW = 2;
   localparam int c_DW = 17;

   localparam int unsigned c_FIB [23] = '{
      1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987, 1597,
      2584, 4181, 6765, 10946, 17711, 28657, 46368 };
   localparam logic [c_DW-1:0] c_FNS01 = 17'd1;
   localparam logic [c_DW-1:0] c_FNS02 = 17'd2;
   localparam logic [c_DW-1:0] c_FNS22 = 17'd46368;

   typedef struct {
      logic [c_N-1:0] valid;
      logic           ordy;
      logic [c_N-1:0] exp_rdy;
      logic           exp_ov;
   } vec_t;

   typedef struct {
      logic [c_LW-1:0] lane;
      logic [c_DW-1:0] data;
   } sb_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   bit   rnd_codes;
   logic [22:0] cur_code [c_N];
   sb_t  sbq [$];
   vec_t tbl [19];

   idp_dec_arb_if #(.N_LANES(c_N), .LANE_W(c_LW), .DOUT_W(c_DW)) bus ();

   idp_dec_arb #(
      .N_LANES (c_N),
      .LANE_W  (c_LW),
      .DOUT_W  (c_DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [c_DW-1:0] ref_dec(input logic [22:0] c);
      int unsigned s;
      s = 0;
      for (int i = 0; i < 23; i++) begin
         if (c[i]) s += c_FIB[i];
      end
      return c_DW'(s);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [c_N-1:0] v, input logic ordy);
      bus.in_valid  = v;
      bus.out_ready = ordy;
      for (int i = 0; i < c_N; i++) bus.in_code[23*i +: 23] = cur_code[i];
   endtask

   // One cycle: drive at the falling edge, check, update scoreboard, wait
   task automatic step(input logic [c_N-1:0] v, input logic ordy,
                       input logic [c_N-1:0] exp_rdy, input logic exp_ov);
      sb_t e;
      drive(v, ordy);
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (bus.out_valid === 1'b1) begin
         chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            chk("out_lane", 64'(bus.out_lane), 64'(sbq[0].lane));
            chk("out_data", 64'(bus.out_data), 64'(sbq[0].data));
            if (ordy) void'(sbq.pop_front());
         end
      end
      for (int g = 0; g < c_N; g++) begin
         if (exp_rdy[g]) begin
            e.lane = c_LW'(g);
            e.data = ref_dec(cur_code[g]);
            sbq.push_back(e);
            if (rnd_codes) cur_code[g] = 23'($urandom);
         end
      end
      @(negedge clk);
   endtask

   // Reset with all lanes requesting; release on a falling edge
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(4'b1111, 1'b1);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_lane", 64'(bus.out_lane), 64'd0);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      rnd_codes = 1'b1;
      for (int i = 0; i < c_N; i++) cur_code[i] = 23'($urandom);
      drive(4'b0000, 1'b1);

      // valid, out_ready, expected in_ready, expected out_valid
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
      tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1};
      tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b1};
      tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
      tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      tbl[10] = '{4'b1010, 1'b0, 4'b0010, 1'b0};
      tbl[11] = '{4'b1010, 1'b0, 4'b1000, 1'b0};
      tbl[12] = '{4'b0010, 1'b0, 4'b0000, 1'b1};
      tbl[13] = '{4'b0010, 1'b0, 4'b0000, 1'b1};
      tbl[14] = '{4'b0010, 1'b0, 4'b0000, 1'b1};
      tbl[15] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
      tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
      tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
      tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

      do_reset();
      foreach (tbl[i]) step(tbl[i].valid, tbl[i].ordy, tbl[i].exp_rdy, tbl[i].exp_ov);
      chk("tbl_drained", 64'(sbq.size()), 64'd0);

      // Lane 2 alone: codes 0 then 1, results back to back
      rnd_codes = 1'b0;
      do_reset();
      cur_code[2] = 23'h000000;
      step(4'b0100, 1'b1, 4'b0100, 1'b0);
      cur_code[2] = 23'h000001;
      step(4'b0100, 1'b1, 4'b0100, 1'b0);
      chk("lane2_first", 64'(bus.out_data), 64'd0);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("lane2_second", 64'(bus.out_data), 64'(c_FNS01));
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 1'b0);

      // Lane 0 bit1 and lane 1 bit22 weights
      do_reset();
      cur_code[0] = 23'h000002;
      cur_code[1] = 23'h400000;
      step(4'b0011, 1'b1, 4'b0001, 1'b0);
      step(4'b0010, 1'b1, 4'b0010, 1'b0);
      chk("fns02", 64'(bus.out_data), 64'(c_FNS02));
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("fns22", 64'(bus.out_data), 64'(c_FNS22));
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 1'b0);

      // Reset while S1 and S2 are both full
      rnd_codes = 1'b1;
      do_reset();
      step(4'b1111, 1'b0, 4'b0001, 1'b0);
      step(4'b1111, 1'b0, 4'b0010, 1'b0);
      drive(4'b1111, 1'b0);
      #1;
      chk("full_out_valid", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_in_ready", 64'(bus.in_ready), 64'd0);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, 1'b1, 4'b0001, 1'b0);
      step(4'b0000, 1'b1, 4'b0000, 1'b0);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 1'b0);
      chk("final_drained", 64'(sbq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/idp_dec_arb.md
Name: idp_dec_arb

Overview:
- Shares a single combinational IDP_dec_23 decoder instance between N_LANES independent TSV receive lanes.
- Each lane presents 23-bit CAC codewords on a valid/ready channel. A round-robin arbiter picks one lane per cycle and registers its codeword into the decoder input.
- The decoded binary word is registered and returned on one output channel, tagged with the source lane.
- The block sits between the TSV lane receivers and the downstream data sink.

Parameters:
- N_LANES, 4, number of requesting lanes (2..8).
- LANE_W, 2, width of the lane tag; equals clog2(N_LANES), minimum 1.
- DOUT_W, `IBLEN23, decoded data width; matches the decoder output width from FNS.vh.

Ports:
- clk  in  1  block clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N_LANES  per-lane codeword valid.
- in_ready  out  N_LANES  per-lane accept. At most one bit is high per cycle.
- in_code  in  23*N_LANES  per-lane codeword; lane i occupies bits [23*i+22 : 23*i].
- out_valid  out  1  decoded word available.
- out_ready  in  1  downstream accept.
- out_data  out  DOUT_W  decoded value.
- out_lane  out  LANE_W  lane index that sourced out_data.

Behaviour:
- Reset (async assert, sync release) sets the following to 0: in_ready, out_valid, out_data, out_lane, s1_valid, s1_code, s1_lane, and the round-robin pointer rr_ptr.
- Pipeline stage S1:
  - Holds s1_code, s1_lane and s1_valid.
  - s1_code drives the shared decoder's codein.
- Pipeline stage S2 is the output register set: out_valid, out_data, out_lane.
- Advance conditions:
  - s2_free = !out_valid | out_ready.
  - s1_free = !s1_valid | s2_free.
- Arbitration (combinational):
  - When s1_free=1, grant the first lane with in_valid=1, searching from rr_ptr upward with wrap-around modulo N_LANES.
  - in_ready[g]=1 for the granted lane only. All bits are 0 when s1_free=0 or no lane is valid.
- On a handshake (in_valid[g] & in_ready[g]):
  - s1_code <= lane g code, s1_lane <= g, s1_valid <= 1.
  - rr_ptr <= (g+1) mod N_LANES.
- If s1_free=1 with no grant: s1_valid <= 0. rr_ptr is unchanged.
- When s1_valid & s2_free: out_data <= decoder(s1_code), out_lane <= s1_lane, out_valid <= 1.
- If s2_free=1 and s1_valid=0: out_valid <= 0.
- When out_valid & !out_ready: out_valid, out_data and out_lane hold stable.
- Latency and throughput:
  - An input accepted at edge t appears on out_* after edge t+1 (2 registers).
  - Throughput is 1 word/cycle with out_ready tied high.
- Fairness:
  - A continuously valid lane waits at most N_LANES-1 accepted transfers before it is granted.
  - No lane is granted twice in a row while any other lane is valid.
- Backpressure:
  - With out_ready=0 the block accepts at most 2 words (S1 + S2), then all in_ready=0.
  - On out_ready rising, S2 drains and S1 moves in the same cycle. A new grant happens in the same cycle (full pipelining, no bubble).
- Protocol rules:
  - A lane must hold in_valid and in_code stable until accepted.
  - The block does not check codeword legality; illegal codewords decode with the same weighted sum.
- Reset mid-operation: in-flight words in S1/S2 are discarded, out_valid drops immediately (async), and rr_ptr returns to 0.

Test Plan:
- Reset with all lanes valid, then release rst_n -> first accepted lane is 0; out_valid=0 until 2 edges after the first handshake.
- Lane 2 only, in_code=23'h000000 then 23'h000001, out_ready=1 -> out_data=0 with out_lane=2, then out_data=`FNS01 with out_lane=2 on the next cycle.
- All 4 lanes continuously valid, out_ready=1 -> grant order 0,1,2,3,0,1,...; one output per cycle; out_lane follows the same sequence.
- out_ready=0 for 5 cycles with lanes 1 and 3 valid -> exactly 2 handshakes (lane 1, then lane 3), then in_ready=0. out_data/out_lane hold the lane-1 result stable. Raising out_ready gives lane-1, lane-3 results back to back.
- Lane 0 code 23'h000002 and lane 1 code 23'h400000, out_ready=1 -> out_data=`FNS02 (lane 0) then `FNS22 (lane 1).
- Assert rst_n=0 while S1 and S2 are full -> out_valid=0 and in_ready=0 asynchronously. After release, no stale word appears and the grant restarts at lane 0.
